ota_offset_trim_ctrl: RTL and testbench
=======================================

// Module: ota_offset_trim_ctrl
// PURPOSE
//  - Digital sequencer for the single-stage OTA's input-offset trim. It runs a SAR calibration:
//    closes the input-short and cal switches, then binary-searches the trim DAC code.
//  - It reads the OTA's comparator-mode output and holds the final code on the trim DAC bus.
//  - Sits in the digital wrapper of the analog macro. trim_code and switch controls drive the
//    analog trim DAC and switches; cmp_in comes from VOUT via a latch.
// PARAMETERS
//  - TRIM_W        6    trim DAC code width (>=2)
//  - SETTLE_CYC    16   cycles each trial code is held before sampling (>=3, covers sync latency)
//  - RECAL_PERIOD  200  idle cycles between automatic recalibrations (used only with OTA_RECAL_EN)
// PORTS
//  - clk        in   1       system clock
//  - rst_n      in   1       asynchronous active-low reset
//  - ena        in   1       block enable; low aborts any calibration
//  - start      in   1       single-cycle calibration request, sampled in IDLE only
//  - cmp_in     in   1       async comparator output; 1 = trial code too low (keep bit)
//  - trim_code  out  TRIM_W  code to trim DAC (trial code while busy)
//  - sw_short   out  1       closes VIN+/VIN- short switch
//  - sw_cal     out  1       puts OTA in open-loop comparator mode
//  - busy       out  1       calibration in progress
//  - done       out  1       one-cycle pulse when a calibration completes
//  - cal_err    out  1       last result railed (all-0 or all-1); sticky until next start
// BEHAVIOUR
//  - Reset values
//    - trim_code = mid-scale (1<<(TRIM_W-1)); the saved code resets to the same value.
//    - sw_short, sw_cal, busy, done and cal_err are all 0; state is IDLE; counters are 0.
//  - cmp_in passes through a 2-FF synchronizer before any use.
//  - FSM states: IDLE, TRIAL, DECIDE, DONE.
//  - IDLE -> TRIAL when ena && start.
//    - Next cycle: busy=1, sw_short=1, sw_cal=1, cal_err cleared.
//    - Working code = saved-bits 0 with only the MSB set; bit index = TRIM_W-1.
//  - TRIAL: hold the trial code for SETTLE_CYC cycles, counting 0..SETTLE_CYC-1, then go to DECIDE.
//  - DECIDE (1 cycle): sample the synced cmp.
//    - cmp = 1: keep the current bit. cmp = 0: clear it.
//    - If bit index > 0: set the next lower bit, decrement the index, return to TRIAL.
//    - Otherwise go to DONE.
//  - DONE (1 cycle): done=1, sw_short=0, sw_cal=0; the final code is latched into the saved code.
//    - cal_err = (code == 0 || code == all-ones).
//    - Next state IDLE, busy=0.
//  - Busy duration: exactly TRIM_W*(SETTLE_CYC+1)+1 cycles (103 at defaults), including the DONE cycle.
//  - trim_code always mirrors the working code while busy and the saved code otherwise.
//  - start while busy: ignored (not queued).
//  - start && !ena: ignored.
//  - ena falls while busy (abort)
//    - Next cycle: state IDLE, busy=0, switches open, done=0.
//    - trim_code = previous saved code; cal_err unchanged.
//  - rst_n low mid-calibration: all outputs return to reset values asynchronously.
// CONFIGURATION
//  - OTA_RECAL_EN defined
//    - An idle counter runs while in IDLE with ena=1.
//    - At RECAL_PERIOD cycles after DONE (or after ena rises), it triggers a calibration exactly as start does.
//    - The counter clears on any entry to TRIAL; it resets to 0 and holds while ena=0.
//  - OTA_RECAL_EN undefined: calibration runs only on start; the idle counter logic is absent.
// STRUCTURE
//  - Package ota_ctrl_pkg holds:
//    - the state enum (IDLE/TRIAL/DECIDE/DONE);
//    - the default TRIM_W and SETTLE_CYC constants;
//    - the mid-scale code function.
//  - Sub-module ota_cmp_sync: parameterised N-stage (default 2) reset-to-0 synchronizer for cmp_in.
//  - Top: FSM, settle counter, bit index, working/saved code registers, optional recal counter.
// TESTING
//  - Comparator model: cmp_in = (trim_code <= TARGET); defaults unless stated.
//  - Reset, then idle 10 cycles
//    -> trim_code=32; all other outputs 0; no done.
//  - TARGET=37, pulse start
//    -> busy high 103 cycles; switches high with busy except the DONE cycle.
//    -> done pulses on cycle 103; trim_code=37; cal_err=0.
//  - TARGET=0, then TARGET=63 (separate runs)
//    -> trim_code=0, cal_err=1; then trim_code=63, cal_err=1.
//    -> A following run with TARGET=20 clears cal_err at start and ends at 20.
//  - After a completed run to 37: TARGET=10, start, drop ena at busy cycle 40
//    -> next cycle busy=0, sw_short=0, sw_cal=0, trim_code=37, no done.
//  - start re-pulsed at busy cycles 5 and 50
//    -> single run, busy length still 103, one done.
//  - OTA_RECAL_EN, RECAL_PERIOD=200, TARGET=37
//    -> after the first done, busy reasserts exactly 200 idle cycles later.
//    -> no recal while ena=0.

Source files
------------

// File: rtl/ota_offset_trim_ctrl_pkg.sv
// Shared types and defaults for the OTA offset-trim sequencer: FSM state
// encoding, default sizes and the mid-scale trim code helper.
package ota_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRIAL,
        ST_DECIDE,
        ST_DONE
    } ota_state_e;

    localparam int unsigned TRIM_W_DEF       = 6;
    localparam int unsigned SETTLE_CYC_DEF   = 16;
    localparam int unsigned RECAL_PERIOD_DEF = 200;

    function automatic int unsigned mid_code(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/ota_offset_trim_ctrl_if.sv
// Control/status bundle between the digital wrapper and the trim sequencer.
// The slave modport is the sequencer side; master is the wrapper/driver side.
interface ota_offset_trim_ctrl_if
    import ota_ctrl_pkg::*;
#(
    parameter int unsigned TRIM_W = TRIM_W_DEF
);
    logic              ena;
    logic              start;
    logic              cmp_in;
    logic [TRIM_W-1:0] trim_code;
    logic              sw_short;
    logic              sw_cal;
    logic              busy;
    logic              done;
    logic              cal_err;

    modport master (
        output ena, start, cmp_in,
        input  trim_code, sw_short, sw_cal, busy, done, cal_err
    );

    modport slave (
        input  ena, start, cmp_in,
        output trim_code, sw_short, sw_cal, busy, done, cal_err
    );
endinterface

// File: rtl/ota_offset_trim_ctrl_cmp_sync.sv
// Reset-to-0 multi-stage synchronizer bringing the latched comparator output
// into the clk domain.
module ota_cmp_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/ota_offset_trim_ctrl.sv
// SAR offset-trim sequencer for the OTA: settles each trial code, samples the
// synced comparator and keeps/clears bits MSB-first. OTA_RECAL_EN adds periodic recalibration.
module ota_offset_trim_ctrl
    import ota_ctrl_pkg::*;
#(
    parameter int unsigned TRIM_W       = TRIM_W_DEF,
    parameter int unsigned SETTLE_CYC   = SETTLE_CYC_DEF
`ifdef OTA_RECAL_EN
    , parameter int unsigned RECAL_PERIOD = RECAL_PERIOD_DEF
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ota_offset_trim_ctrl_if.slave  bus
);
    localparam int unsigned       CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned       IDX_W    = $clog2(TRIM_W);
    localparam logic [TRIM_W-1:0] MID      = TRIM_W'(mid_code(TRIM_W));
    localparam logic [TRIM_W-1:0] ONES     = '1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    ota_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [TRIM_W-1:0] r_code;
    logic [TRIM_W-1:0] r_saved;
    logic [TRIM_W-1:0] r_trim;
    logic              r_sw;
    logic              r_busy;
    logic              r_done;
    logic              r_cal_err;

    logic              w_cmp;
    logic              w_recal;
    logic              w_trigger;
    logic [TRIM_W-1:0] w_bit;
    logic [TRIM_W-1:0] w_decided;

    ota_cmp_sync #(.STAGES(2)) u_cmp_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (bus.cmp_in),
        .o_q     (w_cmp)
    );

    assign w_bit     = {{(TRIM_W-1){1'b0}}, 1'b1} << r_idx;
    // cmp=1 means the trial code is still at or below the offset point: keep the bit
    assign w_decided = w_cmp ? r_code : (r_code & ~w_bit);
    assign w_trigger = bus.ena && (bus.start || w_recal);

`ifdef OTA_RECAL_EN
    localparam int unsigned RC_W = (RECAL_PERIOD > 1) ? $clog2(RECAL_PERIOD) : 1;
    logic [RC_W-1:0] r_idle;

    assign w_recal = (r_idle == RC_W'(RECAL_PERIOD - 1));

    // Counts idle cycles with ena high; cleared while busy, disabled or on trigger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (!bus.ena || r_state != ST_IDLE || w_recal) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_recal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_code    <= MID;
            r_saved   <= MID;
            r_trim    <= MID;
            r_sw      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cal_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != ST_IDLE && !bus.ena) begin
                // Abort: drop back to the last good code, leave cal_err alone
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_sw    <= 1'b0;
                r_trim  <= r_saved;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_trigger) begin
                            r_state   <= ST_TRIAL;
                            r_busy    <= 1'b1;
                            r_sw      <= 1'b1;
                            r_cal_err <= 1'b0;
                            r_code    <= MID;
                            r_trim    <= MID;
                            r_idx     <= IDX_W'(TRIM_W - 1);
                            r_cnt     <= '0;
                        end
                    end
                    ST_TRIAL: begin
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ST_DECIDE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_DECIDE: begin
                        if (r_idx != '0) begin
                            r_code  <= w_decided | (w_bit >> 1);
                            r_trim  <= w_decided | (w_bit >> 1);
                            r_idx   <= r_idx - 1'b1;
                            r_cnt   <= '0;
                            r_state <= ST_TRIAL;
                        end else begin
                            r_code    <= w_decided;
                            r_trim    <= w_decided;
                            r_saved   <= w_decided;
                            r_cal_err <= (w_decided == '0) || (w_decided == ONES);
                            r_done    <= 1'b1;
                            r_sw      <= 1'b0;
                            r_state   <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_trim  <= r_saved;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.trim_code = r_trim;
    assign bus.sw_short  = r_sw;
    assign bus.sw_cal    = r_sw;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.cal_err   = r_cal_err;
endmodule

// File: tb/tb_ota_offset_trim_ctrl.sv
// Bench for ota_offset_trim_ctrl: table of calibration runs, randomized targets
// against an ideal-trim reference, abort/re-start/reset corners, and recal when enabled.
module tb_ota_offset_trim_ctrl;
    localparam int TW       = 6;
    localparam int SC       = 16;
    localparam int BUSY_LEN = TW * (SC + 1) + 1;
    localparam int MAXCODE  = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   target;
    int   checks = 0;
    int   errors = 0;

    ota_offset_trim_ctrl_if #(.TRIM_W(TW)) bus ();

    ota_offset_trim_ctrl #(
        .TRIM_W     (TW),
        .SETTLE_CYC (SC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Comparator model: output high while the applied code is at or below the offset point
    assign bus.cmp_in = (int'(bus.trim_code) <= target);

    typedef struct {
        int tgt;
        int abort_at;
        bit repulse;
        int exp_code;
        int exp_err;
        int exp_len;
        int exp_done;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ideal trim result: largest code the comparator still accepts, clamped to the DAC range
    function automatic int ref_code(input int tgt);
        if (tgt < 0) return 0;
        if (tgt > MAXCODE) return MAXCODE;
        return tgt;
    endfunction

    task automatic run_cal(input int tgt, input int abort_at, input bit repulse,
                           output int blen, output int ndone, output int swbad,
                           output int done_at, output int err1);
        blen = 0; ndone = 0; swbad = 0; done_at = 0; err1 = -1;
        @(negedge clk);
        target    = tgt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 2 * BUSY_LEN; c++) begin
            if (!bus.busy) break;
            blen++;
            if (c == 1) err1 = int'(bus.cal_err);
            if (bus.done) begin
                ndone++;
                done_at = c;
                if (bus.sw_short || bus.sw_cal) swbad++;
            end else if (!bus.sw_short || !bus.sw_cal) begin
                swbad++;
            end
            if (repulse && (c == 5 || c == 50)) bus.start = 1'b1;
            if (c == abort_at) bus.ena = 1'b0;
            @(negedge clk);
            bus.start = 1'b0;
        end
        if (bus.done) ndone++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int blen, ndone, swbad, done_at, err1, stray, exp;

        vecs[0] = '{37, 0,  1'b0, 37, 0, BUSY_LEN, 1};
        vecs[1] = '{0,  0,  1'b0, 0,  1, BUSY_LEN, 1};
        vecs[2] = '{63, 0,  1'b0, 63, 1, BUSY_LEN, 1};
        vecs[3] = '{20, 0,  1'b0, 20, 0, BUSY_LEN, 1};
        vecs[4] = '{37, 0,  1'b0, 37, 0, BUSY_LEN, 1};
        vecs[5] = '{10, 40, 1'b0, 37, 0, 40,       0};
        vecs[6] = '{45, 0,  1'b1, 45, 0, BUSY_LEN, 1};

        rst_n     = 1'b0;
        bus.ena   = 1'b0;
        bus.start = 1'b0;
        target    = 0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        bus.ena = 1'b1;
        stray   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) stray++;
        end
        check("reset_trim", int'(bus.trim_code), 32);
        check("reset_sw_short", int'(bus.sw_short), 0);
        check("reset_sw_cal", int'(bus.sw_cal), 0);
        check("reset_cal_err", int'(bus.cal_err), 0);
        check("reset_idle_activity", stray, 0);

        for (int v = 0; v < 7; v++) begin
            run_cal(vecs[v].tgt, vecs[v].abort_at, vecs[v].repulse,
                    blen, ndone, swbad, done_at, err1);
            check($sformatf("vec%0d_busy_len", v), blen, vecs[v].exp_len);
            check($sformatf("vec%0d_done_cnt", v), ndone, vecs[v].exp_done);
            check($sformatf("vec%0d_done_at", v), done_at,
                  (vecs[v].exp_done != 0) ? BUSY_LEN : 0);
            check($sformatf("vec%0d_switches", v), swbad, 0);
            check($sformatf("vec%0d_err_at_start", v), err1, 0);
            check($sformatf("vec%0d_code", v), int'(bus.trim_code), vecs[v].exp_code);
            check($sformatf("vec%0d_cal_err", v), int'(bus.cal_err), vecs[v].exp_err);
            check($sformatf("vec%0d_sw_after", v), int'(bus.sw_short | bus.sw_cal), 0);
            bus.ena = 1'b1;
        end

        // start while disabled must not launch a run
        @(negedge clk);
        bus.ena   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy) stray++;
        end
        check("start_without_ena", stray, 0);
        bus.ena = 1'b1;

        for (int r = 0; r < 8; r++) begin
            int tgt;
            tgt = int'($urandom_range(0, MAXCODE + 8));
            exp = ref_code(tgt);
            run_cal(tgt, 0, 1'b0, blen, ndone, swbad, done_at, err1);
            check($sformatf("rand%0d_t%0d_code", r, tgt), int'(bus.trim_code), exp);
            check($sformatf("rand%0d_t%0d_err", r, tgt), int'(bus.cal_err),
                  int'(exp == 0 || exp == MAXCODE));
            check($sformatf("rand%0d_busy_len", r), blen, BUSY_LEN);
            check($sformatf("rand%0d_done_cnt", r), ndone, 1);
        end

        // Asynchronous reset in the middle of a run
        run_cal(50, 0, 1'b0, blen, ndone, swbad, done_at, err1);
        @(negedge clk);
        target    = 10;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("midrun_busy_before_reset", int'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_trim", int'(bus.trim_code), 32);
        check("async_rst_sw", int'(bus.sw_short | bus.sw_cal), 0);
        check("async_rst_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_trim", int'(bus.trim_code), 32);
        check("post_rst_busy", int'(bus.busy), 0);

`ifdef OTA_RECAL_EN
        begin
            int idle_cnt;
            run_cal(37, 0, 1'b0, blen, ndone, swbad, done_at, err1);
            check("recal_first_code", int'(bus.trim_code), 37);
            idle_cnt = 1;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (bus.busy) break;
                idle_cnt++;
            end
            check("recal_idle_gap", idle_cnt, 200);
            for (int i = 0; i < 2 * BUSY_LEN; i++) begin
                if (!bus.busy) break;
                @(negedge clk);
            end
            check("recal_run_finished", int'(bus.busy), 0);
            bus.ena = 1'b0;
            stray = 0;
            repeat (400) begin
                @(negedge clk);
                if (bus.busy) stray++;
            end
            check("no_recal_while_disabled", stray, 0);
            bus.ena = 1'b1;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
